// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick function for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int unsigned MaxReq = 32;

  // Searches last+1, last+2, ... (mod num_req) and returns the first requesting index;
  // returns last unchanged when nobody is requesting.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned last,
                                          input int unsigned num_req);
    logic [MaxReq-1:0] rot;
    int unsigned cand;
    int unsigned pick;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      if (!found && (i <= num_req)) begin
        cand = (last + i) % num_req;
        rot  = req >> cand;
        if (rot[0]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_sel.sv
// Combinational round-robin selector: rotate past the last winner, find first, one-hot out.
module rr_priority_sel
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = 2
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] last_i,
  output logic [NumReq-1:0]  grant_oh_o,
  output logic [IdWidth-1:0] grant_idx_o,
  output logic               any_o
);

  logic [MaxReq-1:0] req_ext;
  int unsigned       pick;

  always_comb begin
    req_ext     = MaxReq'(req_i);
    pick        = rr_pick(req_ext, 32'(last_i), NumReq);
    any_o       = |req_i;
    grant_idx_o = IdWidth'(pick);
    grant_oh_o  = '0;
    if (any_o) begin
      grant_oh_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NumReq valid/ready producers.
// Define FIFO_ARB_TAG_EN to prepend the granted requester ID to fifo_data_o.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned NumReq   = 4,
  parameter int unsigned BurstLen = 4,
  localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1,
`ifdef FIFO_ARB_TAG_EN
  localparam int unsigned OutWidth = Width + IdWidth
`else
  localparam int unsigned OutWidth = Width
`endif
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  input  logic [NumReq*Width-1:0]  req_data_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_write_o,
  output logic [OutWidth-1:0]      fifo_data_o,
  output logic [NumReq-1:0]        grant_o,
  output logic                     busy_o
);

  localparam int unsigned CntWidth = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(BurstLen - 1);

  arb_state_e          state_q, state_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic [IdWidth-1:0]  gidx_q, gidx_d;
  logic [IdWidth-1:0]  last_q, last_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0]   sel_oh;
  logic [IdWidth-1:0]  sel_idx;
  logic                sel_any;
  logic                cur_valid;
  logic [Width-1:0]    cur_data;
  logic [Width-1:0]    data_arr [NumReq];

  for (genvar k = 0; k < NumReq; k++) begin : g_data
    assign data_arr[k] = req_data_i[k*Width +: Width];
  end

  assign cur_valid = req_valid_i[gidx_q];
  assign cur_data  = data_arr[gidx_q];

  rr_priority_sel #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_sel (
    .req_i       (req_valid_i),
    .last_i      (last_q),
    .grant_oh_o  (sel_oh),
    .grant_idx_o (sel_idx),
    .any_o       (sel_any)
  );

  // Last pointer resets to NumReq-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IdWidth'(NumReq - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_any) begin
          state_d = ARB_GRANT;
          grant_d = sel_oh;
          gidx_d  = sel_idx;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (!cur_valid) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (!fifo_full_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            last_d  = gidx_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Write side is purely combinational so a full flag blocks the write in the same cycle.
  always_comb begin
    req_ready_o  = '0;
    fifo_write_o = 1'b0;
    fifo_data_o  = '0;
    if (state_q == ARB_GRANT) begin
      req_ready_o[gidx_q] = !fifo_full_i;
      fifo_write_o        = cur_valid & !fifo_full_i;
`ifdef FIFO_ARB_TAG_EN
      fifo_data_o         = {gidx_q, cur_data};
`else
      fifo_data_o         = cur_data;
`endif
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ARB_GRANT);

endmodule
